// File: rtl/door_pkg.sv
// Shared definitions for the garage door supervisor: state encoding,
// state width and default timing parameters.
package door_pkg;

    localparam int unsigned STATE_W            = 3;
    localparam int unsigned TRAVEL_TIMEOUT_DEF = 16;
    localparam int unsigned AUTO_CLOSE_DEF     = 20;
    localparam int unsigned LIGHT_HOLD_DEF     = 30;

    typedef enum logic [STATE_W-1:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    function automatic logic is_moving(input state_e st);
        return (st == ST_OPENING) || (st == ST_CLOSING);
    endfunction

endpackage

// File: rtl/door_timer.sv
// Saturating up-counter with synchronous clear and enable; tc flags the
// terminal value MAX-1, where the count stops rather than wrapping.
module door_timer #(
    parameter int unsigned MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned    W    = $clog2(MAX + 1);
    localparam logic [W-1:0]   TERM = W'(MAX - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d takes a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TERM)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TERM);

endmodule

// File: rtl/door_supervisor.sv
// Garage door supervisor: Moore FSM driving the motor, courtesy light and
// fault indicator from buttons, limit switches and the obstruction sensor.
module door_supervisor
    import door_pkg::*;
#(
    parameter int unsigned TRAVEL_TIMEOUT = TRAVEL_TIMEOUT_DEF,
    parameter int unsigned AUTO_CLOSE     = AUTO_CLOSE_DEF,
    parameter int unsigned LIGHT_HOLD     = LIGHT_HOLD_DEF
) (
    input  logic               clk,
    input  logic               r,
    input  logic               bw,
    input  logic               br,
    input  logic               c,
    input  logic               o,
    input  logic               s,
    output logic               u,
    output logic               d,
    output logic               light,
    output logic               fault,
    output logic [STATE_W-1:0] State
);

    localparam int unsigned   LW         = $clog2(LIGHT_HOLD + 1);
    localparam logic [LW-1:0] LIGHT_LOAD = LW'(LIGHT_HOLD);

    state_e        state_q, state_d;
    logic          resolve_q;
    logic          btn_prev_q;
    logic [LW-1:0] light_cnt_q, light_cnt_d;
    logic          u_q, d_q, light_q, fault_q;

    logic press;
    logic state_change;
    logic travel_tc;
    logic auto_tc;

    assign press        = (bw | br) & ~btn_prev_q;
    assign state_change = (state_d != state_q);

    door_timer #(.MAX(TRAVEL_TIMEOUT)) u_travel_timer (
        .clk (clk),
        .rst (r),
        .clr (state_change),
        .en  (is_moving(state_q)),
        .tc  (travel_tc)
    );

    door_timer #(.MAX(AUTO_CLOSE)) u_auto_close (
        .clk (clk),
        .rst (r),
        .clr ((state_change && (state_d == ST_OPEN)) || s),
        .en  ((state_q == ST_OPEN) && !s),
        .tc  (auto_tc)
    );

    always_comb begin
        state_d = state_q;
        if (resolve_q) begin
            // First edge out of reset only learns where the door physically is.
            if (c && o)      state_d = ST_FAULT;
            else if (o)      state_d = ST_OPEN;
            else if (c)      state_d = ST_CLOSED;
            else             state_d = ST_OPENING;
        end else if ((state_q != ST_FAULT) && c && o) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_CLOSED:  if (press) state_d = ST_OPENING;
                ST_OPENING: begin
                    if (o)              state_d = ST_OPEN;
                    else if (travel_tc) state_d = ST_FAULT;
                end
                ST_OPEN: begin
                    if ((press || auto_tc) && !s) state_d = ST_CLOSING;
                end
                ST_CLOSING: begin
                    if (s || press)     state_d = ST_OPENING;
                    else if (c)         state_d = ST_CLOSED;
                    else if (travel_tc) state_d = ST_FAULT;
                end
                default:    state_d = state_q;
            endcase
        end
    end

    always_comb begin
        light_cnt_d = light_cnt_q;
        if (is_moving(state_q) && !is_moving(state_d)) begin
            light_cnt_d = LIGHT_LOAD;
        end else if (light_cnt_q != '0) begin
            light_cnt_d = light_cnt_q - LW'(1);
        end
    end

    // Outputs are registered from next-state so they track State with no extra lag.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q     <= ST_CLOSED;
            resolve_q   <= 1'b1;
            btn_prev_q  <= 1'b0;
            light_cnt_q <= '0;
            u_q         <= 1'b0;
            d_q         <= 1'b0;
            light_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            resolve_q   <= 1'b0;
            btn_prev_q  <= bw | br;
            light_cnt_q <= light_cnt_d;
            u_q         <= (state_d == ST_OPENING);
            d_q         <= (state_d == ST_CLOSING);
            light_q     <= is_moving(state_d) || (light_cnt_d != '0);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign u     = u_q;
    assign d     = d_q;
    assign light = light_q;
    assign fault = fault_q;
    assign State = state_q;

endmodule

// File: tb/tb_door_supervisor.sv
// Directed self-checking bench for door_supervisor with default parameters.
module tb_door_supervisor;

    logic       clk, r, bw, br, c, o, s;
    logic       u, d, light, fault;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    door_supervisor dut (
        .clk   (clk),
        .r     (r),
        .bw    (bw),
        .br    (br),
        .c     (c),
        .o     (o),
        .s     (s),
        .u     (u),
        .d     (d),
        .light (light),
        .fault (fault),
        .State (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset across two edges, release, then take the resolve edge.
    task automatic do_reset(input logic cv, input logic ov);
        r  = 1'b1;
        bw = 1'b0;
        br = 1'b0;
        s  = 1'b0;
        c  = cv;
        o  = ov;
        tick(2);
        r = 1'b0;
        tick();
    endtask

    int hi_cnt;

    initial begin
        r = 1'b1; bw = 1'b0; br = 1'b0; c = 1'b0; o = 1'b1; s = 1'b0;
        tick(2);
        check("rst_state", state, 0);
        check("rst_u", u, 0);
        check("rst_d", d, 0);
        check("rst_light", light, 0);
        check("rst_fault", fault, 0);

        r = 1'b0;
        tick();
        check("resolve_open_state", state, 2);
        check("resolve_open_u", u, 0);
        check("resolve_open_d", d, 0);

        do_reset(1'b0, 1'b0);
        check("resolve_mid_state", state, 1);
        check("resolve_mid_u", u, 1);

        // Asynchronous reset mid-travel, sampled between clock edges.
        #2 r = 1'b1;
        #1;
        check("async_rst_u", u, 0);
        check("async_rst_state", state, 0);
        tick();
        r = 1'b0;
        tick();

        do_reset(1'b1, 1'b1);
        check("resolve_co_fault", state, 4);

        // Open cycle from Closed with light hold.
        do_reset(1'b1, 1'b0);
        check("closed_state", state, 0);
        bw = 1'b1;
        tick();
        bw = 1'b0;
        c  = 1'b0;
        check("press_opening", state, 1);
        check("press_u", u, 1);
        tick(4);
        check("opening_hold", state, 1);
        o = 1'b1;
        s = 1'b1;
        tick();
        check("reach_open", state, 2);
        check("reach_open_u", u, 0);
        check("light_load", light, 1);
        hi_cnt = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (light) hi_cnt++;
        end
        check("light_hold_cycles", hi_cnt, 29);
        check("light_off", light, 0);
        check("open_blocked_by_s", state, 2);

        // Auto-close after 20 edges in Open.
        do_reset(1'b0, 1'b1);
        tick(19);
        check("auto_close_early", state, 2);
        tick();
        check("auto_close_state", state, 3);
        check("auto_close_d", d, 1);

        // Obstruction restarts the auto-close count.
        do_reset(1'b0, 1'b1);
        tick(9);
        s = 1'b1;
        tick(3);
        s = 1'b0;
        tick(19);
        check("auto_close_s_early", state, 2);
        tick();
        check("auto_close_s_state", state, 3);

        // Obstruction while Closing reverses.
        s = 1'b1;
        tick();
        s = 1'b0;
        check("reverse_state", state, 1);
        check("reverse_u", u, 1);
        check("reverse_d", d, 0);

        // Simultaneous buttons count once; held buttons do not repeat.
        do_reset(1'b1, 1'b0);
        bw = 1'b1;
        br = 1'b1;
        tick();
        c = 1'b0;
        check("dual_press_state", state, 1);
        tick(10);
        check("dual_hold_state", state, 1);
        bw = 1'b0;
        br = 1'b0;
        o  = 1'b1;
        tick();
        check("dual_reach_open", state, 2);
        o  = 1'b0;
        bw = 1'b1;
        tick();
        check("open_press_close", state, 3);
        tick(3);
        check("held_no_repeat", state, 3);
        bw = 1'b0;
        c  = 1'b1;
        tick();
        check("closing_reach_closed", state, 0);
        check("closed_d", d, 0);
        check("closed_light", light, 1);

        // Travel timeout from Opening.
        do_reset(1'b0, 1'b0);
        tick(15);
        check("timeout_early", state, 1);
        tick();
        check("timeout_state", state, 4);
        check("timeout_fault", fault, 1);
        check("timeout_u", u, 0);
        check("timeout_d", d, 0);
        for (int i = 0; i < 2; i++) begin
            bw = 1'b1;
            tick();
            bw = 1'b0;
            tick();
        end
        check("fault_sticky", state, 4);
        #2 r = 1'b1;
        #1;
        check("fault_rst_state", state, 0);
        check("fault_rst_fault", fault, 0);
        tick();

        // Both limit switches in Open force Fault.
        do_reset(1'b0, 1'b1);
        c = 1'b1;
        tick();
        check("open_co_fault", state, 4);

        // Obstruction outranks closed limit while Closing.
        do_reset(1'b0, 1'b1);
        o  = 1'b0;
        bw = 1'b1;
        tick();
        bw = 1'b0;
        check("closing_entry", state, 3);
        s = 1'b1;
        c = 1'b1;
        tick();
        check("closing_s_over_c", state, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
